// File: rtl/rd_pkg.sv
// rtl/rd_pkg.sv - shared widths and borrow generate/propagate pair for the subtract pipe
package rd_pkg;

  localparam int WIDTH = 16;
  localparam int LOG2W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/rd_prefix_cell.sv
// rtl/rd_prefix_cell.sv - borrow prefix combine operator (hi over lo)
module rd_prefix_cell
  import rd_pkg::*;
(
  input  gp_t gp_hi,
  input  gp_t gp_lo,
  output gp_t gp_out
);

  // a group borrows if its upper half generates, or propagates a borrow from the lower half
  always_comb begin
    gp_out.g = gp_hi.g | (gp_hi.p & gp_lo.g);
    gp_out.p = gp_hi.p & gp_lo.p;
  end

endmodule

// File: rtl/rd_sub_pipe.sv
// rtl/rd_sub_pipe.sv - four-stage prefix-borrow subtractor with global stall
module rd_sub_pipe
  import rd_pkg::gp_t;
#(
  parameter int WIDTH = rd_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // position 0 carries borrow-in, position i+1 carries operand bit i
  gp_t [WIDTH:0] gp0, l1, s1_gp, l2, l4, s2_gp, l8, l16;

  logic             s1_v, s2_v, s3_v;
  logic [WIDTH-1:0] s1_t, s2_t, s3_t;
  logic [1:0]       s1_s, s2_s, s3_s;
  logic [WIDTH:0]   s3_g;
  logic [WIDTH:0]   l16_g, l16_p;
  logic [WIDTH-1:0] diff_c;
  logic             unused_p;

  assign in_ready = !rst_n || !out_valid || out_ready;

  // per-bit borrow generate/propagate, bin as the lowest position
  always_comb begin
    gp0[0] = '{g: bin, p: bin};
    for (int i = 0; i < WIDTH; i++) begin
      gp0[i+1] = '{g: ~x[i] & y[i], p: ~(x[i] ^ y[i])};
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : g_sp1
    if (j >= 1) begin : g_cell
      rd_prefix_cell u_cell (.gp_hi(gp0[j]), .gp_lo(gp0[j-1]), .gp_out(l1[j]));
    end else begin : g_pass
      assign l1[j] = gp0[j];
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : g_sp2
    if (j >= 2) begin : g_cell
      rd_prefix_cell u_cell (.gp_hi(s1_gp[j]), .gp_lo(s1_gp[j-2]), .gp_out(l2[j]));
    end else begin : g_pass
      assign l2[j] = s1_gp[j];
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : g_sp4
    if (j >= 4) begin : g_cell
      rd_prefix_cell u_cell (.gp_hi(l2[j]), .gp_lo(l2[j-4]), .gp_out(l4[j]));
    end else begin : g_pass
      assign l4[j] = l2[j];
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : g_sp8
    if (j >= 8) begin : g_cell
      rd_prefix_cell u_cell (.gp_hi(s2_gp[j]), .gp_lo(s2_gp[j-8]), .gp_out(l8[j]));
    end else begin : g_pass
      assign l8[j] = s2_gp[j];
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : g_sp16
    if (j >= 16) begin : g_cell
      rd_prefix_cell u_cell (.gp_hi(l8[j]), .gp_lo(l8[j-16]), .gp_out(l16[j]));
    end else begin : g_pass
      assign l16[j] = l8[j];
    end
  end

  // only the resolved borrows matter past the last span; group propagate has no consumer
  always_comb begin
    for (int j = 0; j <= WIDTH; j++) begin
      l16_g[j] = l16[j].g;
      l16_p[j] = l16[j].p;
    end
  end
  assign unused_p = ^l16_p;

  // borrow into bit i is the resolved prefix at position i
  assign diff_c = s3_t ^ s3_g[WIDTH-1:0];

  // pipeline registers; everything advances together when the output slot frees up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (in_ready) begin
      s1_v      <= in_valid;
      s1_gp     <= l1;
      s1_t      <= x ^ y;
      s1_s      <= {x[WIDTH-1], y[WIDTH-1]};
      s2_v      <= s1_v;
      s2_gp     <= l4;
      s2_t      <= s1_t;
      s2_s      <= s1_s;
      s3_v      <= s2_v;
      s3_g      <= l16_g;
      s3_t      <= s2_t;
      s3_s      <= s2_s;
      out_valid <= s3_v;
      diff      <= diff_c;
      bout      <= s3_g[WIDTH];
      zero      <= (diff_c == '0);
      ovf       <= (s3_s[1] != s3_s[0]) && (diff_c[WIDTH-1] != s3_s[1]);
    end
  end

endmodule

// File: tb/tb_rd_sub_pipe.sv
// tb/tb_rd_sub_pipe.sv - scoreboard bench for rd_sub_pipe
module tb_rd_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, y;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        bout, zero, ovf;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  rd_sub_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .bin(bin),
    .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        z;
    logic        o;
  } res_t;

  res_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    res_t        m;
    r   = {1'b0, a} - {1'b0, b} - {16'b0, c};
    m.d = r[15:0];
    m.b = r[16];
    m.z = (r[15:0] == 16'h0000);
    m.o = (a[15] != b[15]) && (r[15] != a[15]);
    return m;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // scoreboard: retire/compare, stability under stall, then record new acceptances
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      sbq.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_diff", diff, hold_d);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("diff", diff, e.d);
          chk("bout", bout, e.b);
          chk("zero", zero, e.z);
          chk("ovf", ovf, e.o);
          n_pop++;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = diff;
      if (in_valid && in_ready) begin
        sbq.push_back(model(x, y, bin));
        n_push++;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    bit ok;
    int n;
    x = a; y = b; bin = c; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", n, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  // call right after send() returns on an empty pipe with out_ready high
  task automatic latency(input string tag);
    int cnt;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, cnt, 4);
  endtask

  initial begin
    int p0, q0, n;
    logic [15:0] hd;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; bin = 1'b0;
    #1;
    chk("rdy_in_rst", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, zero, ovf}, 0);
    rst_n = 1'b1;
    chk("rdy_after_rst", in_ready, 1);

    // basic subtract and latency
    send(16'h0005, 16'h0003, 1'b0);
    in_valid = 1'b0;
    latency("lat_basic");
    chk("t1_diff", diff, 16'h0002);
    chk("t1_flags", {bout, zero, ovf}, 3'b000);
    drain();

    // borrow-out and signed overflow
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    // borrow-in reaching zero, and all-ones with bin
    send(16'h1234, 16'h1233, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    in_valid = 1'b0;
    drain();

    // backpressure: 6 back-to-back, consumer stalls 3 cycles at first result
    q0 = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'h1007 + 16'(i * 16'h1111), 16'(i * 3), 1'(i));
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        hd = diff;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk("bp_ready_low", in_ready, 0);
          chk("bp_held", diff, hd);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", in_ready, 1);
      end
    join
    drain();
    chk("bp_count", n_pop - q0, 6);

    // reset with three operands in flight
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h4444, 16'h1111, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_flags", {bout, zero, ovf}, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale", out_valid, 0);
    end
    send(16'h00FF, 16'h0100, 1'b0);
    in_valid = 1'b0;
    latency("lat_after_rst");
    drain();

    // random traffic with random backpressure
    p0 = n_push;
    q0 = n_pop;
    n = 0;
    while (n_push - p0 < 10000 && n < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      x         = rnd16();
      y         = rnd16();
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_accepted", n_push - p0, 10000);
    chk("rand_retired", n_pop - q0, 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
